hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5: register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-003 SHALL have port clk_i  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  pipeline run enable; low forces IDLE.
REQ-006 SHALL have port id_rs_i  input  REG_W  rs specifier of the instruction in ID.
REQ-007 SHALL have port id_rt_i  input  REG_W  rt specifier of the instruction in ID.
REQ-008 SHALL have port id_use_rt_i  input  1  ID instruction reads rt.
REQ-009 SHALL have port ex_memread_i  input  1  instruction in EX is a load.
REQ-010 SHALL have port ex_rt_i  input  REG_W  load destination in EX.
REQ-011 SHALL have port branch_taken_i  input  1  level; branch/jump in ID resolved taken.
REQ-012 SHALL have port redirect_i  input  1  single-cycle redirect pulse from a later stage.
REQ-013 SHALL have port mem_stall_i  input  1  level; data memory not ready.
REQ-014 SHALL have port pc_write_o  output  1  PC update enable.
REQ-015 SHALL have port ifid_stall_o  output  1  IF/ID hold.
REQ-016 SHALL have port ifid_flush_o  output  1  IF/ID clear to 32'b0.
REQ-017 SHALL have port idex_bubble_o  output  1  zero ID/EX control fields.
REQ-018 SHALL have port freeze_o  output  1  hold every pipeline register.
REQ-019 SHALL have port state_o  output  2  current state: IDLE=0, RUN=1, MWAIT=2.
REQ-020 SHALL have port stall_cnt_o  output  CNT_W  cycles with pc_write_o=0 outside IDLE.
REQ-021 SHALL have port flush_cnt_o  output  CNT_W  cycles with ifid_flush_o=1.

Function
REQ-022 SHALL define load_use = ex_memread_i & (ex_rt_i!=0) & ((ex_rt_i==id_rs_i) | (id_use_rt_i & ex_rt_i==id_rt_i)).
REQ-023 SHALL keep state in IDLE while start_i=0 and drive all control outputs 0 there; start_i=0 in any state -> IDLE next cycle, pending redirect cleared.
REQ-024 SHALL move IDLE->RUN on the edge sampling start_i=1; no control output asserts in that cycle.
REQ-025 SHALL, in RUN with mem_stall_i=1, drive freeze_o=1, ifid_stall_o=1, pc_write_o=0, ifid_flush_o=0, idex_bubble_o=0, and move to MWAIT.
REQ-026 SHALL, in MWAIT while mem_stall_i=1, hold the REQ-025 outputs and remain in MWAIT.
REQ-027 SHALL set the pending-redirect flag when redirect_i=1 arrives while freeze_o=1; the pulse SHALL NOT be lost.
REQ-028 SHALL, when mem_stall_i=0 (RUN, or MWAIT releasing to RUN), apply same-cycle priority: load_use > flush > normal.
REQ-029 SHALL, on load_use, drive pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, ifid_flush_o=0; a simultaneous branch_taken_i is ignored (the branch re-evaluates next cycle).
REQ-030 SHALL, when no load_use and (branch_taken_i | redirect_i | pending flag), drive ifid_flush_o=1, pc_write_o=1, and clear the pending flag.
REQ-031 SHALL, otherwise, drive pc_write_o=1 and all other control outputs 0.
REQ-032 SHALL retain the pending flag through a load_use cycle and apply it on the first non-load_use, non-frozen cycle.
REQ-033 SHALL compute all control outputs combinationally from state and current inputs (zero latency).
REQ-034 SHALL increment stall_cnt_o on each clock with state!=IDLE and pc_write_o=0, and flush_cnt_o on each clock with ifid_flush_o=1; both saturate at all-ones and never wrap.
REQ-035 SHALL keep counter values across start_i toggles; only reset clears them.

Reset
REQ-036 SHALL, while rst_i=0, immediately force state IDLE, pending flag 0, both counters 0, and all control outputs 0, independent of clk_i.
REQ-037 SHALL, on reset asserted mid-MWAIT with a pending redirect, discard the redirect; after release with start_i=1, RUN is entered after one edge with no flush.

Verification
REQ-038 SHALL cover: start_i=1, ex_memread_i=1, ex_rt_i=5, id_rs_i=5 -> pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1 for one cycle; stall_cnt_o=1.
REQ-039 SHALL cover: load with ex_rt_i=0, id_rs_i=0 -> no stall, pc_write_o=1.
REQ-040 SHALL cover: branch_taken_i=1 with no hazard -> ifid_flush_o=1, pc_write_o=1, flush_cnt_o=1.
REQ-041 SHALL cover: mem_stall_i=1 for 3 cycles with redirect_i pulsed in cycle 2 -> freeze_o=1 for 3 cycles, state_o=2, then ifid_flush_o=1 in the release cycle, state_o=1.
REQ-042 SHALL cover: CNT_W=4, 20 consecutive load_use cycles -> stall_cnt_o stops at 15.
REQ-043 SHALL cover: rst_i dropped between clock edges during MWAIT -> state_o=0 and all outputs 0 before the next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/redirect flushes and
// data-memory freezes, with a latched redirect that survives frozen and
// load-use cycles, plus saturating stall/flush statistics counters.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             redirect_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2
  } state_t;

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;
  logic   pending;
  logic   pending_nxt;
  logic   load_use;

  // Saturating increment: a full counter stays at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Load in EX writes a register the ID instruction reads ($0 never hazards).
  always_comb begin
    load_use = ex_memread_i & (ex_rt_i != REG_ZERO) &
               ((ex_rt_i == id_rs_i) | (id_use_rt_i & (ex_rt_i == id_rt_i)));
  end

  // Next state, pending redirect and zero-latency control outputs.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    pc_write_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    case (state)
      IDLE: begin
        pending_nxt = 1'b0;
        if (start_i) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN, MWAIT: begin
        if (mem_stall_i) begin
          // Memory not ready: hold everything; remember any redirect.
          freeze_o     = 1'b1;
          ifid_stall_o = 1'b1;
          state_nxt    = MWAIT;
          if (redirect_i) begin
            pending_nxt = 1'b1;
          end else begin
            pending_nxt = pending;
          end
        end else begin
          state_nxt = RUN;
          if (load_use) begin
            // Stall wins; a redirect arriving now is kept for later, and a
            // taken branch simply re-evaluates next cycle.
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
            if (redirect_i) begin
              pending_nxt = 1'b1;
            end else begin
              pending_nxt = pending;
            end
          end else if (branch_taken_i | redirect_i | pending) begin
            ifid_flush_o = 1'b1;
            pc_write_o   = 1'b1;
            pending_nxt  = 1'b0;
          end else begin
            pc_write_o = 1'b1;
          end
        end
        if (!start_i) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b0;
        end else begin
          pending_nxt = pending_nxt;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Statistics counters; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= {CNT_W{1'b0}};
      flush_cnt_o <= {CNT_W{1'b0}};
    end else begin
      if ((state != IDLE) && !pc_write_o) begin
        stall_cnt_o <= sat_inc(stall_cnt_o);
      end else begin
        stall_cnt_o <= stall_cnt_o;
      end
      if (ifid_flush_o) begin
        flush_cnt_o <= sat_inc(flush_cnt_o);
      end else begin
        flush_cnt_o <= flush_cnt_o;
      end
    end
  end

  // Expose the current state encoding.
  always_comb begin
    state_o = state;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table of single-cycle RUN cases
// plus hand-written multi-cycle sequences (freeze, pending redirect,
// saturation on a narrow-counter instance, asynchronous reset).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_use_rt_i, ex_memread_i, branch_taken_i, redirect_i, mem_stall_i;

  logic        pc_write, ifid_stall, ifid_flush, idex_bubble, freeze;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_write4, ifid_stall4, ifid_flush4, idex_bubble4, freeze4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       br;
    logic       redir;
    logic       pc;
    logic       stl;
    logic       fl;
    logic       bub;
  } vec_t;

  vec_t tbl [10];

  hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rt_i(id_use_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .branch_taken_i(branch_taken_i), .redirect_i(redirect_i), .mem_stall_i(mem_stall_i),
    .pc_write_o(pc_write), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .freeze_o(freeze), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rt_i(id_use_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .branch_taken_i(branch_taken_i), .redirect_i(redirect_i), .mem_stall_i(mem_stall_i),
    .pc_write_o(pc_write4), .ifid_stall_o(ifid_stall4), .ifid_flush_o(ifid_flush4),
    .idex_bubble_o(idex_bubble4), .freeze_o(freeze4), .state_o(state4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic pc, input logic stl,
                         input logic fl, input logic bub, input logic frz);
    chk({name, ".pc_write"}, int'(pc_write), int'(pc));
    chk({name, ".ifid_stall"}, int'(ifid_stall), int'(stl));
    chk({name, ".ifid_flush"}, int'(ifid_flush), int'(fl));
    chk({name, ".idex_bubble"}, int'(idex_bubble), int'(bub));
    chk({name, ".freeze"}, int'(freeze), int'(frz));
  endtask

  task automatic chk_cnt(input string name);
    chk({name, ".stall_cnt"}, int'(stall_cnt), sat(exp_stall, 65535));
    chk({name, ".flush_cnt"}, int'(flush_cnt), sat(exp_flush, 65535));
    chk({name, ".stall_cnt4"}, int'(stall_cnt4), sat(exp_stall, 15));
    chk({name, ".flush_cnt4"}, int'(flush_cnt4), sat(exp_flush, 15));
  endtask

  task automatic clear_in();
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0; id_use_rt_i = 1'b0;
    ex_memread_i = 1'b0; branch_taken_i = 1'b0; redirect_i = 1'b0; mem_stall_i = 1'b0;
  endtask

  task automatic set_load_use();
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5;
  endtask

  task automatic after_edge_state(input string name, input int exp);
    @(posedge clk);
    #1;
    chk({name, ".state"}, int'(state), exp);
  endtask

  initial begin
    //        memrd ex_rt  rs     rt     use   br    redir  pc    stl   fl    bub
    tbl[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 5'd0,  5'd4,  5'd4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    clear_in();
    start_i = 1'b0;
    rst_i   = 1'b0;
    #12;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.state", int'(state), 0);
    chk_cnt("reset");
    rst_i = 1'b1;
    after_edge_state("idle_hold", 0);

    // IDLE -> RUN: nothing asserts in the start cycle
    @(negedge clk);
    start_i = 1'b1;
    #2;
    chk_ctl("start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge_state("start", 1);

    // Single-cycle RUN vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ex_memread_i = tbl[i].memread; ex_rt_i = tbl[i].ex_rt;
      id_rs_i = tbl[i].rs; id_rt_i = tbl[i].rt; id_use_rt_i = tbl[i].use_rt;
      branch_taken_i = tbl[i].br; redirect_i = tbl[i].redir;
      #2;
      chk_ctl($sformatf("vec%0d", i), tbl[i].pc, tbl[i].stl, tbl[i].fl, tbl[i].bub, 1'b0);
      if (!tbl[i].pc) exp_stall++;
      if (tbl[i].fl) exp_flush++;
      after_edge_state($sformatf("vec%0d", i), 1);
    end
    @(negedge clk);
    clear_in();
    #2;
    chk_cnt("table");

    // Freeze 3 cycles, redirect pulsed in cycle 2, flush on release
    for (int c = 1; c <= 3; c++) begin
      mem_stall_i = 1'b1;
      redirect_i  = (c == 2) ? 1'b1 : 1'b0;
      #0;
      chk_ctl($sformatf("mwait%0d", c), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      after_edge_state($sformatf("mwait%0d", c), 2);
      exp_stall++;
      @(negedge clk);
      #2;
    end
    clear_in();
    #0;
    chk_ctl("release", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_flush++;
    after_edge_state("release", 1);
    @(negedge clk);
    #2;
    chk_ctl("post_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("mwait");

    // Pending redirect held through a load-use release cycle
    mem_stall_i = 1'b1; redirect_i = 1'b1;
    #0;
    chk_ctl("pend_frz", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_stall++;
    after_edge_state("pend_frz", 2);
    @(negedge clk);
    clear_in();
    set_load_use();
    #2;
    chk_ctl("pend_lu", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_stall++;
    after_edge_state("pend_lu", 1);
    @(negedge clk);
    clear_in();
    #2;
    chk_ctl("pend_apply", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_flush++;
    after_edge_state("pend_apply", 1);
    @(negedge clk);
    #2;
    chk_cnt("pend");

    // 20 consecutive load-use cycles: narrow counter saturates at 15
    set_load_use();
    for (int i = 0; i < 20; i++) begin
      #0;
      chk($sformatf("sat%0d.pc_write", i), int'(pc_write), 0);
      exp_stall++;
      @(negedge clk);
      #2;
    end
    clear_in();
    chk_cnt("sat");
    chk("sat.stall_cnt4_max", int'(stall_cnt4), 15);

    // Async reset mid-MWAIT with a pending redirect
    mem_stall_i = 1'b1; redirect_i = 1'b1;
    after_edge_state("rst_mw1", 2);
    @(negedge clk);
    redirect_i = 1'b0;
    #3;
    rst_i = 1'b0;
    #1;
    chk("rst_async.state", int'(state), 0);
    chk_ctl("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_stall = 0;
    exp_flush = 0;
    chk_cnt("rst_async");
    @(negedge clk);
    mem_stall_i = 1'b0;
    #3;
    rst_i = 1'b1;
    #1;
    chk_ctl("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge_state("rst_run", 1);
    @(negedge clk);
    #2;
    chk_ctl("rst_noflush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // One load-use cycle after reset: stall_cnt becomes 1
    @(negedge clk);
    set_load_use();
    #2;
    chk_ctl("lu1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_stall++;
    @(negedge clk);
    clear_in();
    #2;
    chk_ctl("lu1_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("lu1");

    // start_i toggle: back to IDLE, counters retained
    start_i = 1'b0;
    after_edge_state("stop", 0);
    @(negedge clk);
    #2;
    chk_ctl("stopped", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge_state("stopped", 0);
    @(negedge clk);
    start_i = 1'b1;
    after_edge_state("restart", 1);
    @(negedge clk);
    #2;
    chk_cnt("retain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
